feedback_history_mem: RTL
=========================

// Module: feedback_history_mem
// PURPOSE
//  Parametrised per-channel feedback store for the OPLL operator pipeline. The output stage writes
//  each channel's latest sample; the operator reads that channel's last two samples and their sum
//  to form the modulator self-feedback term. Holds DEPTH samples per channel in a ring.
//  Clears itself after reset with a one-entry-per-cycle sweep.
// PARAMETERS
//  NUM_CH   9   channel count (1..16); addresses >= NUM_CH are out of range
//  DEPTH    2   samples kept per channel; power of two, >= 2
//  DATA_W   10  signed sample width (sign + 9-bit magnitude, matches LI format)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-high reset
//  wr         in   1          write strobe, one sample per cycle
//  waddr      in   4          write channel
//  wdata      in   DATA_W     signed sample to push into channel waddr
//  rd         in   1          read request
//  raddr      in   4          read channel
//  rdata_cur  out  DATA_W     most recent sample of raddr (registered)
//  rdata_prev out  DATA_W     sample before rdata_cur (registered)
//  rdata_sum  out  DATA_W+1   rdata_cur + rdata_prev, sign-extended, no saturation
//  rvalid     out  1          high the cycle after an accepted rd
//  init_busy  out  1          high while the clear sweep runs
//  wr_drop    out  1          one-cycle pulse: write discarded (sweep active or waddr out of range)
// BEHAVIOUR
//  - Reset (async): sweep counter = 0, all ring pointers = 0, init_busy = 1, rdata_* = 0,
//    rvalid = 0, wr_drop = 0. Memory contents are undefined until the sweep clears them.
//  - Sweep: NUM_CH*DEPTH cycles. Each cycle writes 0 to one entry, in channel-major order.
//    init_busy falls on the cycle after the last entry is cleared.
//    A reset asserted mid-sweep or mid-operation restarts the sweep from entry 0.
//  - Write: when wr=1, init_busy=0 and waddr<NUM_CH, store wdata at ptr[waddr] and advance
//    ptr[waddr] mod DEPTH. Otherwise the write is dropped and wr_drop pulses the next cycle.
//  - Read: latency is 1. When rd=1, init_busy=0 and raddr<NUM_CH, the next cycle gives:
//    rdata_cur = entry[ptr-1], rdata_prev = entry[ptr-2], rdata_sum computed from those two
//    registered values, rvalid = 1.
//    A read while init_busy=1 or with raddr out of range returns all zeros with rvalid = 1.
//  - With rd=0: rvalid = 0 and rdata_* hold their last values.
//  - Pointer wrap: ptr at DEPTH-1 wraps to 0. Before any write after the sweep, both taps read 0.
//  - Writes to different channels never disturb each other. Reads of other channels are
//    unaffected by a simultaneous write.
// CONFIGURATION
//  FEEDBACK_BYPASS_EN defined: a read and a write on the same channel in the same cycle
//    return the new data. rdata_cur = wdata and rdata_prev = the old entry[ptr-1].
//  FEEDBACK_BYPASS_EN undefined: the same case returns the pre-write contents.
//    The write still commits.
// STRUCTURE
//  - vm2413 package: FB_NUM_CH constant and SIGNED_LI_TYPE / fb_sum_t typedefs.
//    Also a function fb_sum(a,b) that sign-extends both operands and adds them.
//  - Sub-module fb_init_sweeper: sweep counter, clear address/strobe, init_busy.
//  - Top level holds the storage array, per-channel pointers, read registers and the bypass mux.
// TESTING
//  1. Reset, then idle -> init_busy high for exactly 18 cycles (9x2). Every channel then
//     reads cur=0, prev=0, sum=0.
//  2. Write ch3 = +5, then ch3 = -7, then read ch3 -> cur=-7, prev=+5, sum=-2, rvalid=1
//     one cycle after rd.
//  3. Write ch0 = 100, 200, 300, then read -> cur=300, prev=200 (wrap at DEPTH=2).
//     Channels 1..8 still read 0.
//  4. Write during the sweep, and write with waddr=12 -> wr_drop pulses each time and the
//     storage is unchanged. A read of raddr=12 returns 0s.
//  5. Same-cycle write ch5 = 42 and read ch5 (old cur = 9): bypass on -> cur=42, prev=9;
//     bypass off -> cur=9. Either way a later read gives cur=42.
//  6. Assert reset for one cycle mid-sweep, and again after data is written -> sweep restarts.
//     All channels read 0 after 18 cycles.

Source files
------------

// File: rtl/feedback_history_mem_pkg.sv
// -----------------------------------------------------------------------------
// feedback_history_mem_pkg
//   Shared types for the vm2413 operator feedback store: default channel count,
//   the signed LI sample type, the widened sum type and the sum helper.
//   Also holds the state encoding of the post-reset clear sweep.
// -----------------------------------------------------------------------------
package feedback_history_mem_pkg;

    localparam int FB_NUM_CH = 9;
    localparam int FB_DATA_W = 10;

    // Sign + 9-bit magnitude sample, and one extra bit for the two-tap sum.
    typedef logic signed [FB_DATA_W-1:0] SIGNED_LI_TYPE;
    typedef logic signed [FB_DATA_W:0]   fb_sum_t;

    typedef enum logic {
        SWEEP_RUN  = 1'b0,
        SWEEP_DONE = 1'b1
    } sweep_state_e;

    // Sign-extend both taps by one bit and add; the result cannot overflow.
    function automatic fb_sum_t fb_sum(input SIGNED_LI_TYPE a, input SIGNED_LI_TYPE b);
        return {a[FB_DATA_W-1], a} + {b[FB_DATA_W-1], b};
    endfunction

endpackage

// File: rtl/feedback_history_mem_if.sv
// -----------------------------------------------------------------------------
// feedback_history_mem_if
//   Write / read bus of the feedback history store.
//   master: the client (output stage writes, operator reads)
//   slave : the store itself
//   Signals: wr/waddr/wdata (write), rd/raddr (read request),
//            rdata_cur/rdata_prev/rdata_sum/rvalid (read result),
//            init_busy (clear sweep running), wr_drop (write discarded).
// -----------------------------------------------------------------------------
interface feedback_history_mem_if #(
    parameter int DATA_W = 10
);
    logic              wr;
    logic [3:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic [3:0]        raddr;
    logic [DATA_W-1:0] rdata_cur;
    logic [DATA_W-1:0] rdata_prev;
    logic [DATA_W:0]   rdata_sum;
    logic              rvalid;
    logic              init_busy;
    logic              wr_drop;

    modport master (
        output wr, waddr, wdata, rd, raddr,
        input  rdata_cur, rdata_prev, rdata_sum, rvalid, init_busy, wr_drop
    );

    modport slave (
        input  wr, waddr, wdata, rd, raddr,
        output rdata_cur, rdata_prev, rdata_sum, rvalid, init_busy, wr_drop
    );
endinterface

// File: rtl/feedback_history_mem_init_sweeper.sv
// -----------------------------------------------------------------------------
// fb_init_sweeper
//   Clears the feedback store after reset, one entry per cycle, in flat index
//   order (channel-major). init_busy stays high while entries are being cleared
//   and drops the cycle after the last one.
//   Ports: clk, reset (async, active high), clr_en (clear strobe),
//          clr_idx (flat entry index to clear), init_busy.
// -----------------------------------------------------------------------------
module fb_init_sweeper
    import feedback_history_mem_pkg::*;
#(
    parameter int TOTAL  = 18,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SWEEP_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP_RUN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = SWEEP_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = SWEEP_DONE;
            end
        endcase
    end

    always_comb begin
        clr_en    = (state_q == SWEEP_RUN);
        clr_idx   = cnt_q;
        init_busy = (state_q == SWEEP_RUN);
    end

endmodule

// File: rtl/feedback_history_mem.sv
// -----------------------------------------------------------------------------
// feedback_history_mem
//   Per-channel ring of the last DEPTH operator output samples. The output
//   stage pushes one sample per cycle; the operator reads the newest two
//   samples of a channel and their sign-extended sum one cycle later.
//   Ports: clk, reset (async, active high), bus (feedback_history_mem_if.slave).
//   Optional feature macro FEEDBACK_BYPASS_EN: a same-channel read and write in
//   one cycle returns the freshly written sample as rdata_cur. Without it the
//   read sees the pre-write contents (the write still commits).
// -----------------------------------------------------------------------------
module feedback_history_mem
    import feedback_history_mem_pkg::*;
#(
    parameter int NUM_CH = FB_NUM_CH,
    parameter int DEPTH  = 2,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    feedback_history_mem_if.slave bus
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam int             TOTAL    = NUM_CH * DEPTH;
    localparam int             ADDR_W   = $clog2(TOTAL);
    localparam logic [4:0]     NUM_CH_L = 5'(NUM_CH);

    // Flat entry index = ch*DEPTH + slot; DEPTH is a power of two so this is a
    // concatenation. The cast only drops bits that are zero for in-range channels.
    function automatic logic [ADDR_W-1:0] flat_idx(input logic [3:0] ch,
                                                   input logic [PTR_W-1:0] slot);
        return ADDR_W'({ch, slot});
    endfunction

    logic [DATA_W-1:0] mem [TOTAL];

    logic [PTR_W-1:0]  ptr_q [NUM_CH];
    logic [PTR_W-1:0]  ptr_d [NUM_CH];
    logic [DATA_W-1:0] rdata_cur_q,  rdata_cur_d;
    logic [DATA_W-1:0] rdata_prev_q, rdata_prev_d;
    logic              rvalid_q,     rvalid_d;
    logic              wr_drop_q,    wr_drop_d;

    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;
    logic              init_busy;

    logic              wr_ok, rd_ok;
    logic [PTR_W-1:0]  wptr, rptr;
    logic [ADDR_W-1:0] cur_idx, prev_idx;
    logic [DATA_W-1:0] rd_cur, rd_prev;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    fb_init_sweeper #(
        .TOTAL  (TOTAL),
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clk       (clk),
        .reset     (reset),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .init_busy (init_busy)
    );

    assign wr_ok = bus.wr & ~init_busy & ({1'b0, bus.waddr} < NUM_CH_L);
    assign rd_ok = bus.rd & ~init_busy & ({1'b0, bus.raddr} < NUM_CH_L);

    // Current write pointer of waddr and read pointer of raddr.
    always_comb begin
        wptr = '0;
        rptr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.waddr == 4'(c)) wptr = ptr_q[c];
            if (bus.raddr == 4'(c)) rptr = ptr_q[c];
        end
    end

    // ptr points at the slot the next write lands in, so the newest sample
    // sits at ptr-1 and the one before it at ptr-2 (both modulo DEPTH).
    assign cur_idx  = flat_idx(bus.raddr, rptr - PTR_W'(1));
    assign prev_idx = flat_idx(bus.raddr, rptr - PTR_W'(2));

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ptr_d[c] = ptr_q[c];
            if (wr_ok && (bus.waddr == 4'(c))) ptr_d[c] = ptr_q[c] + PTR_W'(1);
        end
    end

    // Single write port: the sweep and client writes never overlap because
    // client writes are refused while the sweep runs.
    always_comb begin
        mem_we    = clr_en | wr_ok;
        mem_widx  = clr_en ? clr_idx : flat_idx(bus.waddr, wptr);
        mem_wdata = clr_en ? '0 : bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_comb begin
        rd_cur  = mem[cur_idx];
        rd_prev = mem[prev_idx];
`ifdef FEEDBACK_BYPASS_EN
        // The incoming sample becomes the newest tap; the old newest shifts to prev.
        if (wr_ok && rd_ok && (bus.waddr == bus.raddr)) begin
            rd_prev = rd_cur;
            rd_cur  = bus.wdata;
        end
`endif
        rdata_cur_d  = rdata_cur_q;
        rdata_prev_d = rdata_prev_q;
        rvalid_d     = bus.rd;
        if (bus.rd) begin
            if (rd_ok) begin
                rdata_cur_d  = rd_cur;
                rdata_prev_d = rd_prev;
            end else begin
                rdata_cur_d  = '0;
                rdata_prev_d = '0;
            end
        end
        wr_drop_d = bus.wr & ~wr_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
            rdata_cur_q  <= '0;
            rdata_prev_q <= '0;
            rvalid_q     <= 1'b0;
            wr_drop_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rdata_cur_q  <= rdata_cur_d;
            rdata_prev_q <= rdata_prev_d;
            rvalid_q     <= rvalid_d;
            wr_drop_q    <= wr_drop_d;
        end
    end

    // The sum is formed from the registered taps, so it always matches them.
    generate
        if (DATA_W == FB_DATA_W) begin : g_li_sum
            assign bus.rdata_sum = fb_sum(rdata_cur_q, rdata_prev_q);
        end else begin : g_generic_sum
            assign bus.rdata_sum = {rdata_cur_q[DATA_W-1], rdata_cur_q}
                                 + {rdata_prev_q[DATA_W-1], rdata_prev_q};
        end
    endgenerate

    assign bus.rdata_cur  = rdata_cur_q;
    assign bus.rdata_prev = rdata_prev_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.init_busy  = init_busy;
    assign bus.wr_drop    = wr_drop_q;

endmodule
